// File: rtl/mem_arbiter.sv
// Serialises each CPU step into an optional data phase and an instruction fetch
// on one shared bus, then pulses the CPU clock enable. Optional: ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_cpu_iaddr,
  input  logic [31:0] i_cpu_daddr,
  input  logic [31:0] i_cpu_dwdata,
  input  logic [3:0]  i_cpu_dwe,
  input  logic        i_cpu_drd,
  input  logic        i_cpu_stall,
  output logic        o_cpu_ce,
  output logic [31:0] o_cpu_idata,
  output logic [31:0] o_cpu_ddata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_we,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  if (2 ** TIMEOUT_W <= TIMEOUT_CYCLES || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_arbiter: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;
  logic        ce_q, ce_d;
  logic [31:0] idata_q, idata_d;
  logic [31:0] ddata_q, ddata_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        load_q, load_d;
  logic        in_phase;
  logic        expire;
  logic        phase_done;

  // Byte-lane offsets are resolved by the core; the bus only sees word addresses.
  logic unused_lane_bits;
  assign unused_lane_bits = ^{i_cpu_iaddr[1:0], i_cpu_daddr[1:0]};

  assign in_phase = (state_q == S_DATA) || (state_q == S_FETCH);

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  // An ack in the final allowed cycle still wins over the abort.
  assign expire = in_phase && !i_mem_ack &&
                  (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    tmo_d = tmo_q | expire;
    if (in_phase && !phase_done) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign phase_done = in_phase && (i_mem_ack || expire);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ce_d    = ce_q;
    idata_d = idata_q;
    ddata_d = ddata_q;
    iaddr_d = iaddr_q;
    load_d  = load_q;
    case (state_q)
      S_IDLE: begin
        iaddr_d = {i_cpu_iaddr[31:2], 2'b00};
        req_d   = 1'b1;
        ce_d    = 1'b0;
        if ((|i_cpu_dwe) || i_cpu_drd) begin
          state_d = S_DATA;
          addr_d  = {i_cpu_daddr[31:2], 2'b00};
          we_d    = i_cpu_dwe;
          wdata_d = i_cpu_dwdata;
          // Write wins when the core asserts both strobes.
          load_d  = i_cpu_drd && (i_cpu_dwe == 4'b0000);
        end else begin
          state_d = S_FETCH;
          addr_d  = {i_cpu_iaddr[31:2], 2'b00};
          we_d    = 4'b0000;
          load_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (phase_done) begin
          if (load_q) ddata_d = expire ? 32'h0 : i_mem_rdata;
          state_d = S_FETCH;
          addr_d  = iaddr_q;
          we_d    = 4'b0000;
        end
      end
      S_FETCH: begin
        if (phase_done) begin
          idata_d = expire ? NOP_INSN : i_mem_rdata;
          state_d = S_STEP;
          req_d   = 1'b0;
          ce_d    = 1'b1;
        end
      end
      default: begin
        if (!i_cpu_stall) begin
          state_d = S_IDLE;
          ce_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      ce_q    <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
      iaddr_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ce_q    <= ce_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      iaddr_q <= iaddr_d;
      load_q  <= load_d;
    end
  end

  assign o_cpu_ce    = ce_q;
  assign o_cpu_idata = idata_q;
  assign o_cpu_ddata = ddata_q;
  assign o_mem_req   = req_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = we_q;

endmodule
